// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares one combinational ALU between two requesters. Each operation walks
// through three states:
//   IDLE : pick a requester (round-robin under contention), latch its
//          operands/opcode into the operand registers on the handshake.
//   EXEC : the ALU sees the latched operands; its result, branch flag and the
//          "opcode above OPMAX" flag are captured into the response registers.
//   RESP : the response is presented to the granted requester only and held
//          until that requester consumes it.
// An operation therefore takes at least three cycles, and a new request is
// never accepted in the cycle the previous response is consumed.
//
// Ports
//   clk, reset_n                    clock (rising edge), async active-low reset
//   req{0,1}_valid / _ready         request handshake per requester
//   req{0,1}_a, _b, _op             request operands and opcode
//   alu_a, alu_b, alu_op            operands/opcode to the shared ALU
//   alu_c, alu_branch_cond          ALU result and branch flag (combinational)
//   rsp{0,1}_valid / _ready         response handshake per requester
//   rsp_c, rsp_branch, rsp_illegal  captured response, shared by both ports
// ---------------------------------------------------------------------------
module alu_arbiter #(
  parameter int WIDTH = 24,
  parameter int OPMAX = 12
) (
  input  logic             clk,
  input  logic             reset_n,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_op,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_op,

  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_c,
  input  logic             alu_branch_cond,

  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_c,
  output logic             rsp_branch,
  output logic             rsp_illegal
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Requester ports gathered into arrays so the datapath can index by id.
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req_a [2];
  logic [WIDTH-1:0] req_b [2];
  logic [3:0]       req_op [2];
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};
  assign req_a[0]  = req0_a;
  assign req_a[1]  = req1_a;
  assign req_b[0]  = req0_b;
  assign req_b[1]  = req1_b;
  assign req_op[0] = req0_op;
  assign req_op[1] = req1_op;

  assign req0_ready = req_ready[0];
  assign req1_ready = req_ready[1];
  assign rsp0_valid = rsp_valid[0];
  assign rsp1_valid = rsp_valid[1];

  // State and datapath registers
  state_t           state_q,       state_d;
  logic [WIDTH-1:0] a_q,           a_d;
  logic [WIDTH-1:0] b_q,           b_d;
  logic [3:0]       op_q,          op_d;
  logic             gid_q,         gid_d;    // requester owning the in-flight op
  logic             last_q,        last_d;   // requester granted most recently
  logic [WIDTH-1:0] rsp_c_q,       rsp_c_d;
  logic             rsp_branch_q,  rsp_branch_d;
  logic             rsp_illegal_q, rsp_illegal_d;

  // Round-robin pick. Requester 1 wins when it is the only one asking, or
  // when both ask and requester 0 was the last one served. last_q resets to
  // 1 so requester 0 wins the first contention after reset.
  logic grant_id;
  logic any_valid;
  logic op_illegal;

  assign any_valid  = |req_valid;
  assign grant_id   = req_valid[1] & (~req_valid[0] | ~last_q);
  assign op_illegal = 32'(op_q) > OPMAX;

  // Ready and response-valid are pure decodes of state and id, one per port.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign req_ready[gi] = (state_q == IDLE) && req_valid[gi] && (grant_id == 1'(gi));
    assign rsp_valid[gi] = (state_q == RESP) && (gid_q == 1'(gi));
  end

  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    op_d          = op_q;
    gid_d         = gid_q;
    last_d        = last_q;
    rsp_c_d       = rsp_c_q;
    rsp_branch_d  = rsp_branch_q;
    rsp_illegal_d = rsp_illegal_q;

    unique case (state_q)
      IDLE: begin
        // Any valid request is accepted immediately, so the handshake is
        // implied by any_valid here.
        if (any_valid) begin
          a_d     = req_a[grant_id];
          b_d     = req_b[grant_id];
          op_d    = req_op[grant_id];
          gid_d   = grant_id;
          last_d  = grant_id;
          state_d = EXEC;
        end
      end

      EXEC: begin
        rsp_c_d       = alu_c;
        rsp_branch_d  = alu_branch_cond;
        rsp_illegal_d = op_illegal;
        state_d       = RESP;
      end

      RESP: begin
        if (rsp_ready[gid_q]) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      a_q           <= '0;
      b_q           <= '0;
      op_q          <= '0;
      gid_q         <= 1'b0;
      last_q        <= 1'b1;
      rsp_c_q       <= '0;
      rsp_branch_q  <= 1'b0;
      rsp_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      op_q          <= op_d;
      gid_q         <= gid_d;
      last_q        <= last_d;
      rsp_c_q       <= rsp_c_d;
      rsp_branch_q  <= rsp_branch_d;
      rsp_illegal_q <= rsp_illegal_d;
    end
  end

  // The ALU only ever sees the latched operands, so requesters may change
  // their ports freely once accepted.
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_op      = op_q;
  assign rsp_c       = rsp_c_q;
  assign rsp_branch  = rsp_branch_q;
  assign rsp_illegal = rsp_illegal_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//
// Directed bench for alu_arbiter. A behavioural ALU drives alu_c and
// alu_branch_cond from the DUT's alu_* outputs. Expected responses are
// pushed to a scoreboard queue at each accepted request and popped when the
// DUT presents a response.
//
// ALU opcode map used by the bench model:
//   0 add  1 sub  2 and  3 or  4 xor  5 sll  6 srl  7 sra  8 slt
//   9 bne  10 beq  11 blt  12 bge  (branches return c = 0)
//   13..15 illegal: c = 0, branch = 0
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

  localparam int W = 24;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]   req0_op, req1_op;
  logic [W-1:0] alu_a, alu_b, alu_c;
  logic [3:0]   alu_op;
  logic         alu_branch_cond;
  logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [W-1:0] rsp_c;
  logic         rsp_branch, rsp_illegal;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W), .OPMAX(12)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_c(alu_c), .alu_branch_cond(alu_branch_cond),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_c(rsp_c), .rsp_branch(rsp_branch), .rsp_illegal(rsp_illegal)
  );

  // Returns {branch, c}
  function automatic logic [W:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [3:0] op);
    logic [W-1:0] c;
    logic         br;
    c  = '0;
    br = 1'b0;
    case (op)
      4'd0:  c = a + b;
      4'd1:  c = a - b;
      4'd2:  c = a & b;
      4'd3:  c = a | b;
      4'd4:  c = a ^ b;
      4'd5:  c = a << b[4:0];
      4'd6:  c = a >> b[4:0];
      4'd7:  c = $signed(a) >>> b[4:0];
      4'd8:  c = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      4'd9:  br = (a != b);
      4'd10: br = (a == b);
      4'd11: br = ($signed(a) < $signed(b));
      4'd12: br = ($signed(a) >= $signed(b));
      default: begin
        c  = '0;
        br = 1'b0;
      end
    endcase
    return {br, c};
  endfunction

  always_comb {alu_branch_cond, alu_c} = alu_ref(alu_a, alu_b, alu_op);

  typedef struct {
    logic         id;
    logic [W-1:0] c;
    logic         br;
    logic         ill;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic set_req(input logic k, input logic v, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [3:0] op);
    if (k) begin
      req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
    end
  endtask

  task automatic push_exp(input logic k, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [3:0] op);
    exp_t         e;
    logic [W:0]   r;
    r     = alu_ref(a, b, op);
    e.id  = k;
    e.c   = r[W-1:0];
    e.br  = r[W];
    e.ill = (op > 4'd12);
    sb.push_back(e);
  endtask

  // Called at a negedge while a response should be showing.
  task automatic check_rsp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_rsp0_valid"}, rsp0_valid, (e.id == 1'b0));
      chk({tag, "_rsp1_valid"}, rsp1_valid, (e.id == 1'b1));
      chk({tag, "_rsp_c"},      rsp_c,      e.c);
      chk({tag, "_rsp_branch"}, rsp_branch, e.br);
      chk({tag, "_rsp_illegal"}, rsp_illegal, e.ill);
      $display("rsp %s: id=%0d c=0x%06h br=%0d ill=%0d", tag, e.id, rsp_c, rsp_branch, rsp_illegal);
    end
  endtask

  // Called at a negedge with the request already driven; waits (bounded)
  // for the ready of requester k and returns just before the handshake edge.
  task automatic accept(input logic k, input string tag);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (k ? req1_ready : req0_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_ready"}, got, 1);
    if (got) chk({tag, "_other_ready"}, (k ? req0_ready : req1_ready), 0);
  endtask

  // From the handshake edge onwards: EXEC check, RESP check, optional
  // backpressure of bp cycles, then return to IDLE.
  task automatic complete(input logic k, input logic [W-1:0] a, input logic [3:0] op,
                          input int bp, input string tag);
    logic [W-1:0] hold_c;
    @(negedge clk);
    chk({tag, "_exec_rsp_valid"}, {rsp1_valid, rsp0_valid}, 0);
    chk({tag, "_exec_req_ready"}, {req1_ready, req0_ready}, 0);
    chk({tag, "_exec_alu_a"}, alu_a, a);
    chk({tag, "_exec_alu_op"}, alu_op, op);
    @(negedge clk);
    check_rsp(tag);
    hold_c = rsp_c;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk({tag, "_bp_valid"}, (k ? rsp1_valid : rsp0_valid), 1);
      chk({tag, "_bp_rsp_c"}, rsp_c, hold_c);
      chk({tag, "_bp_req0_ready"}, req0_ready, 0);
    end
    if (k) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_done_valid"}, {rsp1_valid, rsp0_valid}, 0);
    if (bp > 0) begin
      chk({tag, "_idle_req0_ready"}, req0_ready, 1);
      req0_valid = 1'b0;
    end
  endtask

  task automatic run_op(input logic k, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] op, input int bp, input string tag);
    @(negedge clk);
    if (bp > 0) begin
      if (k) rsp1_ready = 1'b0; else rsp0_ready = 1'b0;
    end
    set_req(k, 1'b1, a, b, op);
    accept(k, tag);
    push_exp(k, a, b, op);
    @(posedge clk);
    #1;
    // Scramble the port after acceptance; the in-flight op must not notice.
    set_req(k, 1'b0, ~a, ~b, ~op);
    if (bp > 0) set_req(1'b0, 1'b1, 24'h0000AA, 24'h000055, 4'd3);
    complete(k, a, op, bp, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic want;
    reset_n    = 1'b0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    set_req(1'b0, 1'b0, '0, '0, '0);
    set_req(1'b1, 1'b0, '0, '0, '0);

    // Reset state
    #2;
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
    chk("rst_rsp_c", rsp_c, 0);
    chk("rst_rsp_flags", {rsp_branch, rsp_illegal}, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Contention right after reset: requester 0 first, then alternation
    @(negedge clk);
    set_req(1'b0, 1'b1, 24'd1, 24'd1, 4'd0);
    set_req(1'b1, 1'b1, 24'd6, 24'd3, 4'd2);
    for (int i = 0; i < 4; i++) begin
      want = (i % 2) == 1;
      #1;
      chk($sformatf("cont%0d_req0_ready", i), req0_ready, !want);
      chk($sformatf("cont%0d_req1_ready", i), req1_ready, want);
      if (want) push_exp(1'b1, 24'd6, 24'd3, 4'd2);
      else      push_exp(1'b0, 24'd1, 24'd1, 4'd0);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("cont%0d_exec_rsp_valid", i), {rsp1_valid, rsp0_valid}, 0);
      chk($sformatf("cont%0d_exec_req_ready", i), {req1_ready, req0_ready}, 0);
      @(negedge clk);
      check_rsp($sformatf("cont%0d", i));
      @(negedge clk);
    end
    set_req(1'b0, 1'b0, '0, '0, '0);
    set_req(1'b1, 1'b0, '0, '0, '0);

    // Single requests, including repeat grants to the same requester
    run_op(1'b0, 24'd5, 24'd3, 4'd1, 0, "single_sub");
    run_op(1'b0, 24'hFFFFF9, 24'd3, 4'd8, 0, "repeat_slt");
    run_op(1'b0, 24'h800001, 24'd4, 4'd7, 0, "sra");

    // Branches and the OPMAX boundary
    run_op(1'b1, 24'd4, 24'd4, 4'd10, 0, "beq_taken");
    run_op(1'b1, 24'd4, 24'd4, 4'd9,  0, "bne_not");
    run_op(1'b1, 24'd4, 24'd4, 4'd12, 0, "op12_legal");
    run_op(1'b1, 24'd4, 24'd4, 4'd13, 0, "op13_illegal");
    run_op(1'b1, 24'd9, 24'd2, 4'd15, 0, "op15_illegal");

    // Response backpressure on requester 1 while requester 0 waits
    run_op(1'b1, 24'h123456, 24'h00F0F0, 4'd4, 5, "backpressure");

    // Reset pulse while a response is pending on requester 0
    @(negedge clk);
    rsp0_ready = 1'b0;
    set_req(1'b0, 1'b1, 24'd7, 24'd2, 4'd0);
    accept(1'b0, "rst_run");
    push_exp(1'b0, 24'd7, 24'd2, 4'd0);
    @(posedge clk);
    #1;
    set_req(1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    check_rsp("rst_run");
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
    chk("rst_mid_rsp_c", rsp_c, 0);
    chk("rst_mid_alu_a", alu_a, 0);
    @(negedge clk);
    reset_n    = 1'b1;
    rsp0_ready = 1'b1;
    chk("rst_rel_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
    // Requester 0 served last before reset; it must still win after reset.
    set_req(1'b0, 1'b1, 24'd10, 24'd4, 4'd1);
    set_req(1'b1, 1'b1, 24'd8,  24'd1, 4'd3);
    accept(1'b0, "post_rst");
    push_exp(1'b0, 24'd10, 24'd4, 4'd1);
    @(posedge clk);
    #1;
    set_req(1'b0, 1'b0, '0, '0, '0);
    set_req(1'b1, 1'b0, '0, '0, '0);
    complete(1'b0, 24'd10, 4'd1, 0, "post_rst");

    chk("sb_drained", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
